// File: rtl/fetch_buffer_stage.sv
// rtl/fetch_buffer_stage.sv - instruction fetch request issue and in-order response buffer
// Optional 0-cycle response bypass to decode: define FETCH_BUF_BYPASS_EN.
module fetch_buffer_stage #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h80000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_inst,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [XLEN-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] buf_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [31:0]     r_mem_inst [DEPTH];
  logic [XLEN-1:0] r_mem_pc   [DEPTH];

  logic [CW:0]     w_credit;
  logic            w_req_ok;
  logic            w_req_fire;
  logic            w_drop;
  logic            w_accept;
  logic            w_fifo_valid;
  logic            w_push;
  logic            w_pop;

  // Buffered plus in-flight entries never exceed DEPTH, so a response always has a slot.
  assign w_credit       = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req_ok       = !redirect && (w_credit < (CW+1)'(DEPTH));
  assign w_req_fire     = w_req_ok && imem_req_ready;
  assign imem_req_valid = rst_n && w_req_ok;
  assign imem_req_addr  = r_fetch_pc;

  assign w_drop       = imem_rsp_valid && (redirect || (r_drop_cnt != '0));
  assign w_accept     = imem_rsp_valid && !w_drop;
  assign w_fifo_valid = (r_count != '0);
  assign w_pop        = w_fifo_valid && out_ready;
  assign buf_count    = r_count;

`ifdef FETCH_BUF_BYPASS_EN
  logic w_bypass;
  // w_accept already excludes redirect and drop-pending responses.
  assign w_bypass  = !w_fifo_valid && w_accept;
  assign out_valid = w_fifo_valid || w_bypass;
  assign out_inst  = w_bypass ? imem_rsp_inst : r_mem_inst[r_rptr];
  assign out_pc    = w_bypass ? r_rsp_pc : r_mem_pc[r_rptr];
  assign w_push    = w_accept && !(w_bypass && out_ready);
`else
  assign out_valid = w_fifo_valid;
  assign out_inst  = r_mem_inst[r_rptr];
  assign out_pc    = r_mem_pc[r_rptr];
  assign w_push    = w_accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
        r_rsp_pc   <= redirect_pc;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        // A response landing in the redirect cycle is already discarded here.
        r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_accept)   r_rsp_pc   <= r_rsp_pc + XLEN'(4);
        if (w_push)     r_wptr     <= r_wptr + PW'(1);
        if (w_pop)      r_rptr     <= r_rptr + PW'(1);
        if (w_push && !w_pop)      r_count <= r_count + CW'(1);
        else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        if (w_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
      if (w_req_fire && !imem_rsp_valid)      r_outstanding <= r_outstanding + CW'(1);
      else if (!w_req_fire && imem_rsp_valid) r_outstanding <= r_outstanding - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wptr] <= imem_rsp_inst;
      r_mem_pc[r_wptr]   <= r_rsp_pc;
    end
  end

endmodule
